// File: rtl/div.sv
// div: sequential 32-bit signed restoring divider (MIPS DIV semantics); optional DIV_ZERO_EN adds the div0 flag
module div #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             init,
    input  logic             stop,
    output logic [NBITS-1:0] hi,
    output logic [NBITS-1:0] lo,
    output logic             busy,
    output logic             done
`ifdef DIV_ZERO_EN
    ,
    output logic             div0
`endif
);
    typedef enum logic {IDLE, CALC} state_t;
    state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [NBITS-1:0] quo_q, quo_d, rem_q, rem_d, absb_q, absb_d;
    logic [NBITS-1:0] hi_q, hi_d, lo_q, lo_d;
    logic sa_q, sa_d, sb_q, sb_d, done_q, done_d;
    logic [NBITS:0] sh_rem, trial;
    logic go, accept;
    assign go = (state_q == IDLE) && init && !stop;
`ifdef DIV_ZERO_EN
    logic div0_q, div0_d, dz;
    assign dz = go && (b == '0);
    assign accept = go && !dz;
    assign div0 = div0_q;
`else
    assign accept = go;
`endif
    assign sh_rem = {rem_q, quo_q[NBITS-1]};
    assign trial = sh_rem - {1'b0, absb_q};
    assign hi = hi_q;
    assign lo = lo_q;
    assign busy = (state_q == CALC);
    assign done = done_q;
    // Next state: accept a start, iterate while the counter runs, then sign-correct and publish
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        absb_d = absb_q;
        sa_d = sa_q;
        sb_d = sb_q;
        hi_d = hi_q;
        lo_d = lo_q;
        done_d = 1'b0;
`ifdef DIV_ZERO_EN
        div0_d = dz ? 1'b1 : (accept ? 1'b0 : div0_q);
        done_d = dz;
`endif
        if (accept) begin
            sa_d = a[NBITS-1];
            sb_d = b[NBITS-1];
            quo_d = a[NBITS-1] ? -a : a;
            absb_d = b[NBITS-1] ? -b : b;
            rem_d = '0;
            cnt_d = 6'd32;
            state_d = CALC;
        end else if (state_q == CALC) begin
            if (stop) begin
                state_d = IDLE;
                cnt_d = '0;
            end else if (cnt_q != '0) begin
                rem_d = trial[NBITS] ? sh_rem[NBITS-1:0] : trial[NBITS-1:0];
                quo_d = {quo_q[NBITS-2:0], ~trial[NBITS]};
                cnt_d = cnt_q - 6'd1;
            end else begin
                lo_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
                hi_d = sa_q ? -rem_q : rem_q;
                done_d = 1'b1;
                state_d = IDLE;
            end
        end
    end
    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            absb_q <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            done_q <= 1'b0;
`ifdef DIV_ZERO_EN
            div0_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            absb_q <= absb_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            done_q <= done_d;
`ifdef DIV_ZERO_EN
            div0_q <= div0_d;
`endif
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for div; expected {hi,lo} pushed at start, popped when done pulses
module tb_div;
    logic clk = 1'b0;
    logic rst, init, stop, busy, done;
    logic [31:0] a, b, hi, lo;
`ifdef DIV_ZERO_EN
    logic div0;
`endif
    int checks = 0;
    int passed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int lat, bc;

    always #5 clk = ~clk;

    div dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .init(init), .stop(stop),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
`ifdef DIV_ZERO_EN
        , .div0(div0)
`endif
    );

    // Reference: native signed division, with the hardware's divide-by-zero and overflow results
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x;
        sy = y;
        if (y == 32'h0) return {x, x[31] ? 32'h1 : 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    // Start a division from the current negedge; return latency to done and busy cycle count
    task automatic run(input logic [31:0] xa, input logic [31:0] xb, output int l, output int bcnt);
        a = xa;
        b = xb;
        init = 1'b1;
        l = 0;
        bcnt = 0;
        @(negedge clk);
        init = 1'b0;
        while (!done && l < 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init = 1'b0;
        stop = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else passed++;
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags got %b want 00", {busy, done}); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_q.push_back({32'd2, 32'd14});
        run(32'd100, 32'd7, lat, bc);
        checks++;
        if (lat !== 33) $display("FAIL basic_latency got %0d want 33", lat); else passed++;
        checks++;
        if (bc !== 33) $display("FAIL basic_busy got %0d want 33", bc); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_low got %b want 0", busy); else passed++;
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL basic_result got %h want %h", {hi, lo}, e); else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_signs();
        logic [31:0] va[4] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] vb[4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [63:0] ve[4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD},
                               {32'hFFFFFFFF, 32'd3}, {32'h0, 32'h80000000}};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ve[i]);
            run(va[i], vb[i], lat, bc);
            checks++;
            if (lat !== 33) $display("FAIL signs_latency[%0d] got %0d want 33", i, lat); else passed++;
            e = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== e) $display("FAIL signs_result[%0d] got %h want %h", i, {hi, lo}, e); else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = (i < 3) ? $urandom : 32'($urandom_range(1, 300)) ^ {32{x[0]}};
            if (y == 32'h0) y = 32'd1;
            exp_q.push_back(model(x, y));
            run(x, y, lat, bc);
            e = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== e) $display("FAIL random[%0d] %h/%h got %h want %h", i, x, y, {hi, lo}, e); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(model(32'd1000, 32'hFFFFFFFD));
        exp_q.push_back(model(32'hFFFFFC18, 32'd7));
        run(32'd1000, 32'hFFFFFFFD, lat, bc);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL b2b_first got %h want %h", {hi, lo}, e); else passed++;
        run(32'hFFFFFC18, 32'd7, lat, bc);
        checks++;
        if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else passed++;
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL b2b_second got %h want %h", {hi, lo}, e); else passed++;
    endtask

    task automatic test_abort();
        bit seen;
        exp_q.push_back({32'd2, 32'd14});
        run(32'd100, 32'd7, lat, bc);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL abort_setup got %h want %h", {hi, lo}, e); else passed++;
        a = 32'd50;
        b = 32'd5;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (9) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL abort_no_done got %b want 0", seen); else passed++;
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL abort_hold got %h want %h", {hi, lo}, {32'd2, 32'd14}); else passed++;
    endtask

    task automatic test_ignored_init();
        exp_q.push_back({32'd2, 32'd6});
        a = 32'd20;
        b = 32'd3;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'd1000;
        b = 32'd10;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        a = '0;
        b = '0;
        lat = 5;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 33) $display("FAIL ignored_latency got %0d want 33", lat); else passed++;
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL ignored_result got %h want %h", {hi, lo}, e); else passed++;
    endtask

    task automatic test_reset_mid();
        a = 32'd40;
        b = 32'd3;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({hi, lo, busy, done} !== 66'h0) $display("FAIL rstmid_async got %h want 0", {hi, lo, busy, done}); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back({32'd0, 32'd3});
        run(32'd9, 32'd3, lat, bc);
        checks++;
        if (lat !== 33) $display("FAIL rstmid_latency got %0d want 33", lat); else passed++;
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL rstmid_result got %h want %h", {hi, lo}, e); else passed++;
    endtask

    task automatic test_div_zero();
`ifdef DIV_ZERO_EN
        a = 32'd5;
        b = 32'd0;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        checks++;
        if ({div0, done, busy} !== 3'b110) $display("FAIL dz_flags got %b want 110", {div0, done, busy}); else passed++;
        checks++;
        if ({hi, lo} !== {32'd0, 32'd3}) $display("FAIL dz_hold got %h want %h", {hi, lo}, {32'd0, 32'd3}); else passed++;
        @(negedge clk);
        checks++;
        if ({div0, done} !== 2'b10) $display("FAIL dz_sticky got %b want 10", {div0, done}); else passed++;
        exp_q.push_back({32'd1, 32'd4});
        run(32'd9, 32'd2, lat, bc);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL dz_after got %h want %h", {hi, lo}, e); else passed++;
        checks++;
        if (div0 !== 1'b0) $display("FAIL dz_clear got %b want 0", div0); else passed++;
`else
        exp_q.push_back({32'd5, 32'hFFFFFFFF});
        exp_q.push_back({32'hFFFFFFFB, 32'd1});
        run(32'd5, 32'd0, lat, bc);
        checks++;
        if (lat !== 33) $display("FAIL dz_latency got %0d want 33", lat); else passed++;
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL dz_pos got %h want %h", {hi, lo}, e); else passed++;
        run(32'hFFFFFFFB, 32'd0, lat, bc);
        e = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== e) $display("FAIL dz_neg got %h want %h", {hi, lo}, e); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_random();
        test_back_to_back();
        test_abort();
        test_ignored_init();
        test_reset_mid();
        test_div_zero();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
